hazard_stall_ctrl: RTL and testbench

//  Pipeline sequencing controller for the 16-bit 5-stage cpu (IF/ID/EX/M/WB).

---
 rtl/hazard_stall_ctrl.sv | 152 +++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
//============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Pipeline sequencing controller for the 16-bit 5-stage CPU
//            (IF/ID/EX/M/WB). Detects load-use hazards and taken branches,
//            drives PC/IF/ID/ID-EX write enables, IF/ID flush, the ID-stage
//            bubble mux select and the EX/M bubble. Sequences multi-cycle
//            EX ops (mul/div) by freezing the front end, and keeps a
//            saturating count of stall cycles.
// Ports    : clk, reset_n (async, active-low)
//            id_rs1, id_rs2, id_uses_rs2 : ID-stage source operands
//            ex_rd, ex_memRead, ex_md_op : EX-stage instruction info
//            branch_taken                : taken branch/jump resolved in ID
//            stat_clr                    : synchronous clear of stall_cycles
//            pc_write, ifid_write, ifid_flush, bubble_sel, idex_write,
//            exm_bubble, md_busy         : pipeline controls (Mealy)
//            state                       : 00 RUN, 01 MD_WAIT, 10 MD_DONE
//            stall_cycles                : saturating stall statistic
// Revision : 1.0 - initial release
//============================================================================
module hazard_stall_ctrl #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       id_rs1,
    input  logic [3:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic [3:0]       ex_rd,
    input  logic             ex_memRead,
    input  logic             branch_taken,
    input  logic             ex_md_op,
    input  logic             stat_clr,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             bubble_sel,
    output logic             idex_write,
    output logic             exm_bubble,
    output logic             md_busy,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_WAIT = 2'b01,
        ST_MD_DONE = 2'b10
    } state_t;

    localparam logic             c_MD_EN   = (MD_LATENCY > 1);
    localparam logic [3:0]       c_MD_INIT = (MD_LATENCY > 1) ? 4'(MD_LATENCY - 2) : 4'd0;
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_md_cnt;
    logic [3:0]       w_md_cnt_nxt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_hz;
    logic             w_mdgo;

    // Register 0 is an ordinary register here, so no zero-register masking.
    assign w_hz   = ex_memRead & ((ex_rd == id_rs1) | (id_uses_rs2 & (ex_rd == id_rs2)));
    assign w_mdgo = ex_md_op & c_MD_EN & (r_state == ST_RUN);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_RUN;
            r_md_cnt       <= 4'd0;
            r_stall_cycles <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
            if (stat_clr) begin
                r_stall_cycles <= '0;
            end else if (!pc_write && (r_stall_cycles != c_CNT_MAX)) begin
                r_stall_cycles <= r_stall_cycles + 1'b1;
            end
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        bubble_sel   = 1'b0;
        idex_write   = 1'b1;
        exm_bubble   = 1'b0;
        md_busy      = 1'b0;
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;

        case (r_state)
            ST_MD_WAIT: begin
                // Front end frozen; ID-stage hazards and branches are moot.
                pc_write   = 1'b0;
                ifid_write = 1'b0;
                idex_write = 1'b0;
                exm_bubble = 1'b1;
                md_busy    = 1'b1;
                // Leave when the count would reach zero, so the entry cycle
                // plus the wait cycles total MD_LATENCY-1 stalled cycles.
                if (r_md_cnt <= 4'd1) begin
                    w_state_nxt  = ST_MD_DONE;
                    w_md_cnt_nxt = 4'd0;
                end else begin
                    w_md_cnt_nxt = r_md_cnt - 4'd1;
                end
            end
            default: begin
                // RUN and MD_DONE; the released op is still in EX during
                // MD_DONE, which is why w_mdgo is gated to RUN only.
                if (r_state != ST_RUN) begin
                    w_state_nxt = ST_RUN;
                end
                if (w_mdgo) begin
                    pc_write     = 1'b0;
                    ifid_write   = 1'b0;
                    idex_write   = 1'b0;
                    exm_bubble   = 1'b1;
                    md_busy      = 1'b1;
                    w_state_nxt  = ST_MD_WAIT;
                    w_md_cnt_nxt = c_MD_INIT;
                end else if (w_hz) begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    bubble_sel = 1'b1;
                end else if (branch_taken) begin
                    ifid_flush = 1'b1;
                end
            end
        endcase

        // Hold the pipeline in a safe, squashed configuration during reset.
        if (!reset_n) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            ifid_flush = 1'b1;
            bubble_sel = 1'b1;
            idex_write = 1'b0;
            exm_bubble = 1'b1;
            md_busy    = 1'b0;
        end
    end

    assign state        = r_state;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module   : tb_hazard_stall_ctrl
// Purpose  : Directed-vector bench for hazard_stall_ctrl. The driver pushes
//            hand-computed expected outputs into a queue; a monitor on the
//            falling edge pops and compares.
// Revision : 1.0 - initial release
//============================================================================
module tb_hazard_stall_ctrl;

    // Control group order: {pc_write, ifid_write, ifid_flush, bubble_sel,
    //                       idex_write, exm_bubble, md_busy}
    localparam logic [6:0] c_DEF = 7'b1100100;
    localparam logic [6:0] c_HZ  = 7'b0001100;
    localparam logic [6:0] c_BR  = 7'b1110100;
    localparam logic [6:0] c_MD  = 7'b0000011;
    localparam logic [6:0] c_RST = 7'b0011010;
    localparam logic [1:0] RUN = 2'b00, WT = 2'b01, DN = 2'b10;

    logic        clk;
    logic        reset_n;
    logic [3:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs2, ex_memRead, branch_taken, ex_md_op, stat_clr;
    logic        pc_write, ifid_write, ifid_flush, bubble_sel, idex_write;
    logic        exm_bubble, md_busy;
    logic [1:0]  state;
    logic [15:0] stall_cycles;

    typedef struct {
        logic [24:0] exp;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_err    = 0;

    hazard_stall_ctrl #(.MD_LATENCY(4), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_memRead   (ex_memRead),
        .branch_taken (branch_taken),
        .ex_md_op     (ex_md_op),
        .stat_clr     (stat_clr),
        .pc_write     (pc_write),
        .ifid_write   (ifid_write),
        .ifid_flush   (ifid_flush),
        .bubble_sel   (bubble_sel),
        .idex_write   (idex_write),
        .exm_bubble   (exm_bubble),
        .md_busy      (md_busy),
        .state        (state),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge and queue the
    // expected response for that cycle.
    task automatic drv(input logic rn, input logic clr, input logic md,
                       input logic br, input logic mr, input logic u2,
                       input logic [3:0] rd, input logic [3:0] r1,
                       input logic [3:0] r2, input logic [6:0] ctl,
                       input logic [1:0] st, input logic [15:0] cnt,
                       input string nm, input bit chk = 1'b1);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n      = rn;
        stat_clr     = clr;
        ex_md_op     = md;
        branch_taken = br;
        ex_memRead   = mr;
        id_uses_rs2  = u2;
        ex_rd        = rd;
        id_rs1       = r1;
        id_rs2       = r2;
        if (chk) begin
            e.exp = {ctl, st, cnt};
            e.nm  = nm;
            exp_q.push_back(e);
        end
    endtask

    // Monitor: outputs are settled by the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_t e;
            logic [24:0] act;
            e   = exp_q.pop_front();
            act = {pc_write, ifid_write, ifid_flush, bubble_sel, idex_write,
                   exm_bubble, md_busy, state, stall_cycles};
            n_checks++;
            if (act !== e.exp) begin
                n_err++;
                $display("FAIL %s: got ctl=%b st=%b cnt=%h, expected ctl=%b st=%b cnt=%h",
                         e.nm, act[24:18], act[17:16], act[15:0],
                         e.exp[24:18], e.exp[17:16], e.exp[15:0]);
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 1.5 ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 0; stat_clr = 0; ex_md_op = 0; branch_taken = 0;
        ex_memRead = 0; id_uses_rs2 = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0;

        //   rn clr md br mr u2  rd  r1  r2   ctl    st   cnt
        drv(0, 0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2, c_RST, RUN, 16'd0, "reset_forced");
        drv(1, 0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd2, c_DEF, RUN, 16'd0, "idle_defaults");
        drv(1, 0, 0, 0, 1, 0, 4'd3, 4'd3, 4'd0, c_HZ,  RUN, 16'd0, "hz_rs1");
        drv(1, 0, 0, 0, 0, 0, 4'd3, 4'd3, 4'd0, c_DEF, RUN, 16'd1, "cnt_after_hz");
        drv(1, 0, 0, 0, 1, 0, 4'd5, 4'd0, 4'd5, c_DEF, RUN, 16'd1, "rs2_unused");
        drv(1, 0, 0, 0, 1, 1, 4'd5, 4'd0, 4'd5, c_HZ,  RUN, 16'd1, "hz_rs2");
        drv(1, 0, 0, 1, 0, 0, 4'd5, 4'd0, 4'd5, c_BR,  RUN, 16'd2, "branch_flush");
        drv(1, 0, 0, 1, 1, 0, 4'd3, 4'd3, 4'd0, c_HZ,  RUN, 16'd2, "hz_over_branch");
        drv(1, 0, 0, 0, 1, 0, 4'd0, 4'd0, 4'd7, c_HZ,  RUN, 16'd3, "hz_reg0");
        drv(1, 1, 0, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_DEF, RUN, 16'd4, "stat_clr");
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  RUN, 16'd0, "md_entry");
        drv(1, 0, 1, 1, 1, 0, 4'd3, 4'd3, 4'd7, c_MD,  WT,  16'd1, "md_wait1_ignore");
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  WT,  16'd2, "md_wait2");
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_DEF, DN,  16'd3, "md_done");
        drv(1, 0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_DEF, RUN, 16'd3, "md_back_run");
        // Back-to-back multi-cycle ops
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  RUN, 16'd3, "b2b_entry");
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  WT,  16'd4, "b2b_wait1");
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  WT,  16'd5, "b2b_wait2");
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_DEF, DN,  16'd6, "b2b_done_no_retrig");
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  RUN, 16'd6, "b2b_retrigger");
        drv(1, 0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  WT,  16'd7, "b2b2_wait1");
        drv(1, 0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  WT,  16'd8, "b2b2_wait2");
        drv(1, 0, 0, 0, 1, 0, 4'd3, 4'd3, 4'd7, c_HZ,  DN,  16'd9, "hz_in_md_done");
        drv(1, 0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_DEF, RUN, 16'd10, "run_after_done");
        // Reset in the middle of MD_WAIT
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  RUN, 16'd10, "rst_md_entry");
        drv(1, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_MD,  WT,  16'd11, "rst_md_wait1");
        drv(0, 0, 1, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_RST, RUN, 16'd0, "rst_mid_wait");
        drv(1, 0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd7, c_DEF, RUN, 16'd0, "after_rst_release");
        // Saturation: hazard held for 70000 cycles
        for (int k = 0; k < 70000; k++) begin
            drv(1, 0, 0, 0, 1, 0, 4'd9, 4'd9, 4'd0, c_HZ, RUN,
                (k > 65535) ? 16'hFFFF : 16'(k), $sformatf("sat_k%0d", k),
                (k == 0) || (k == 65534) || (k == 65535) || (k == 65536) || (k == 69999));
        end
        drv(1, 1, 0, 0, 1, 0, 4'd9, 4'd9, 4'd0, c_HZ,  RUN, 16'hFFFF, "sat_clr_cycle");
        drv(1, 0, 0, 0, 0, 0, 4'd0, 4'd1, 4'd0, c_DEF, RUN, 16'd0, "sat_cleared");

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_err++;
            $display("FAIL drain: %0d expected responses left unchecked, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
`default_nettype wire
